coin_pulse_sched: RTL

Coin-event scheduler between the player input sources and the arcade core's single `coin` input. It synchronises and debounces up to NSRC raw coin requests from the USB, DB9 and keyboard coin paths, and counts each debounced press as a pending credit per source. It then serves the sources round-robin, emitting one fixed-width coin pulse per credit, separated by a fixed gap, so the core's I/O custom sees every coin.

---
 rtl/coin_pulse_sched.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/coin_pulse_sched.sv
// coin_pulse_sched: sync/debounce NSRC coin requests, queue credits per source,
// and replay them round-robin as fixed-width coin pulses with a fixed gap.
module coin_pulse_sched #(
  parameter int NSRC      = 4,
  parameter int PULSE_CYC = 1800000,
  parameter int GAP_CYC   = 1800000,
  parameter int DEB_CYC   = 360000,
  parameter int QDEPTH    = 7
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic [NSRC-1:0]         req,
  input  logic                    enable,
  input  logic                    clr_ovf,
  output logic                    coin_out,
  output logic [$clog2(NSRC)-1:0] grant_idx,
  output logic                    busy,
  output logic                    pending_any,
  output logic [NSRC-1:0]         ovf
);

  localparam int GW   = $clog2(NSRC);
  localparam int PW   = $clog2(QDEPTH + 1);
  localparam int DW   = $clog2(DEB_CYC + 1);
  localparam int MAXC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int TW   = $clog2(MAXC + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
  localparam logic [PW-1:0] QMAX     = PW'(QDEPTH);
  localparam logic [TW-1:0] P_LAST   = TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] G_LAST   = TW'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} st_t;

  logic [NSRC-1:0] s1_q, s2_q, acc_q, press_q;
  logic [DW-1:0]   deb_q [NSRC];
  logic [PW-1:0]   pend_q [NSRC];
  logic [PW-1:0]   pend_d [NSRC];
  logic [NSRC-1:0] ovf_q, ovf_d, dec;
  logic            any_q;

  st_t             state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            coin_q, coin_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   rr_q, rr_d;
  logic            found;
  logic [GW-1:0]   pick;

  // press_q is a one-cycle event registered alongside the accepted level
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      acc_q   <= '0;
      press_q <= '0;
      for (int i = 0; i < NSRC; i++) deb_q[i] <= '0;
    end else begin
      s1_q    <= req;
      s2_q    <= s1_q;
      press_q <= '0;
      for (int i = 0; i < NSRC; i++) begin
        if (s2_q[i] == acc_q[i]) begin
          deb_q[i] <= '0;
        end else if (deb_q[i] == DEB_LAST) begin
          deb_q[i]   <= '0;
          acc_q[i]   <= s2_q[i];
          press_q[i] <= s2_q[i];
        end else begin
          deb_q[i] <= deb_q[i] + DW'(1);
        end
      end
    end
  end

  always_comb begin
    ovf_d = ovf_q & ~{NSRC{clr_ovf}};
    for (int i = 0; i < NSRC; i++) begin
      pend_d[i] = pend_q[i];
      if (press_q[i] && !dec[i]) begin
        if (pend_q[i] == QMAX) ovf_d[i] = 1'b1;
        else pend_d[i] = pend_q[i] + PW'(1);
      end else if (!press_q[i] && dec[i]) begin
        pend_d[i] = pend_q[i] - PW'(1);
      end
    end
  end

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= NSRC; k++) begin
      int idx;
      idx = (int'(rr_q) + k) % NSRC;
      if (!found && pend_q[idx] != '0) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    coin_d  = coin_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    dec     = '0;
    unique case (state_q)
      IDLE: begin
        if (enable && found) begin
          dec[pick] = 1'b1;
          rr_d      = pick;
          grant_d   = pick;
          timer_d   = P_LAST;
          coin_d    = 1'b1;
          state_d   = PULSE;
        end
      end
      PULSE: begin
        if (timer_q == '0) begin
          coin_d  = 1'b0;
          timer_d = G_LAST;
          state_d = GAP;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      GAP: begin
        if (timer_q == '0) state_d = IDLE;
        else timer_d = timer_q - TW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      coin_q  <= 1'b0;
      grant_q <= '0;
      rr_q    <= GW'(NSRC - 1);
      ovf_q   <= '0;
      any_q   <= 1'b0;
      for (int i = 0; i < NSRC; i++) pend_q[i] <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      coin_q  <= coin_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      ovf_q   <= ovf_d;
      any_q   <= 1'b0;
      for (int i = 0; i < NSRC; i++) begin
        pend_q[i] <= pend_d[i];
        if (pend_q[i] != '0) any_q <= 1'b1;
      end
    end
  end

  assign coin_out    = coin_q;
  assign grant_idx   = grant_q;
  assign busy        = (state_q != IDLE);
  assign pending_any = any_q;
  assign ovf         = ovf_q;

endmodule
